// File: rtl/remap_vs_gen.sv
// VS regenerator: counts DE-rising lines from the selected input VS edge and emits a
// programmable-width VS pulse at cfg_line_target + LINE_SHIFT, with a missing-VS watchdog.
module remap_vs_gen #(
  parameter int CNT_W      = 16,
  parameter int PW_W       = 8,
  parameter int LINE_SHIFT = 200
) (
  input  logic             mpt_clk,
  input  logic             mpt_rst_n,
  input  logic             vid_vs_in,
  input  logic             vid_de_in,
  input  logic             vid_locked,
  input  logic             cfg_vs_pol,
  input  logic [CNT_W-1:0] cfg_line_target,
  input  logic [PW_W-1:0]  cfg_pulse_len,
  input  logic [CNT_W-1:0] cfg_line_timeout,
  output logic             vid_vs_out,
  output logic [CNT_W-1:0] v_ycnt,
  output logic [CNT_W-1:0] frame_lines,
  output logic             frame_lines_vld,
  output logic             timeout_err,
  output logic             cfg_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_COUNT   = 2'd2;
  localparam logic [1:0] ST_FIRED   = 2'd3;

  logic [1:0]      st;
  logic            vs_1d, vs_2d, de_1d, de_2d;
  logic            vs_edge, de_edge;
  logic [CNT_W:0]  target_sum;
  logic            tgt_hit, wdog_hit, fire;
  logic [PW_W-1:0] pulse_cnt, pulse_len_eff;

  assign vs_edge = cfg_vs_pol ? (vs_1d & ~vs_2d) : (~vs_1d & vs_2d);
  assign de_edge = de_1d & ~de_2d;

  // One extra bit so an out-of-range target is flagged instead of silently wrapping
  assign target_sum = {1'b0, cfg_line_target} + (CNT_W+1)'(LINE_SHIFT);
  assign tgt_hit    = (v_ycnt == target_sum[CNT_W-1:0]);
  assign wdog_hit   = (cfg_line_timeout != '0) && (v_ycnt == cfg_line_timeout);

  // vs_edge and the watchdog both take precedence over firing
  assign fire = vid_locked && (st == ST_COUNT) && !vs_edge && !wdog_hit &&
                tgt_hit && !cfg_err;

  assign pulse_len_eff = (cfg_pulse_len == '0) ? PW_W'(1) : cfg_pulse_len;

  always_ff @(posedge mpt_clk) begin
    if (!mpt_rst_n) begin
      vs_1d           <= 1'b0;
      vs_2d           <= 1'b0;
      de_1d           <= 1'b0;
      de_2d           <= 1'b0;
      cfg_err         <= 1'b0;
      st              <= ST_IDLE;
      v_ycnt          <= '0;
      frame_lines     <= '0;
      frame_lines_vld <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      vs_1d           <= vid_vs_in;
      vs_2d           <= vs_1d;
      de_1d           <= vid_de_in;
      de_2d           <= de_1d;
      cfg_err         <= target_sum[CNT_W];
      frame_lines_vld <= 1'b0;
      timeout_err     <= 1'b0;
      if (!vid_locked) begin
        st     <= ST_IDLE;
        v_ycnt <= '0;
      end else begin
        case (st)
          ST_IDLE: st <= ST_WAIT_VS;
          ST_WAIT_VS: begin
            v_ycnt <= '0;
            if (vs_edge) st <= ST_COUNT;
          end
          default: begin
            if (vs_edge) begin
              frame_lines     <= v_ycnt;
              frame_lines_vld <= 1'b1;
              v_ycnt          <= '0;
              st              <= ST_COUNT;
            end else if (wdog_hit) begin
              timeout_err <= 1'b1;
              v_ycnt      <= '0;
              st          <= ST_WAIT_VS;
            end else begin
              if (de_edge) v_ycnt <= v_ycnt + 1'b1;
              if (fire)    st     <= ST_FIRED;
            end
          end
        endcase
      end
    end
  end

  // Pulse length is captured at fire; a refire restarts the full length
  always_ff @(posedge mpt_clk) begin
    if (!mpt_rst_n || !vid_locked) begin
      vid_vs_out <= 1'b0;
      pulse_cnt  <= '0;
    end else if (fire) begin
      vid_vs_out <= 1'b1;
      pulse_cnt  <= pulse_len_eff - 1'b1;
    end else if (vid_vs_out) begin
      if (pulse_cnt == '0) vid_vs_out <= 1'b0;
      else                 pulse_cnt  <= pulse_cnt - 1'b1;
    end
  end

endmodule
